// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder terminating INCR read/write bursts of 64-byte beats in block RAM.
// Build option: define AXI_MEM_SLAVE_ERR_EN to return SLVERR for out-of-range or non-64-byte bursts.
module axi_mem_slave #(
   parameter int unsigned MEM_LD = 10,
   parameter int unsigned ID_W   = 16,
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ID_W-1:0]   awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [7:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic              awvalid,
   output logic              awready,
   input  logic [511:0]      wdata,
   input  logic [63:0]       wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ID_W-1:0]   arid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [511:0]      rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready
);

   localparam int unsigned Depth = 2 ** MEM_LD;

   typedef logic [MEM_LD-1:0] idx_t;
   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic {RIdle, RData} r_state_e;

   // Holds both ready signals low while reset is asserted and for the first edge after it.
   logic active_q;

   logic aw_err, ar_err;
   logic unused_bits;

`ifdef AXI_MEM_SLAVE_ERR_EN
   assign aw_err      = (awaddr[ADDR_W-1:MEM_LD+6] != '0) || (awsize != 3'b110);
   assign ar_err      = (araddr[ADDR_W-1:MEM_LD+6] != '0) || (arsize != 3'b110);
   assign unused_bits = ^{awaddr[5:0], araddr[5:0], wlast};
`else
   assign aw_err      = 1'b0;
   assign ar_err      = 1'b0;
   assign unused_bits = ^{awaddr[ADDR_W-1:MEM_LD+6], awaddr[5:0], awsize,
                          araddr[ADDR_W-1:MEM_LD+6], araddr[5:0], arsize, wlast};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
      end else begin
         active_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- write path
   w_state_e        w_state_q, w_state_d;
   logic [ID_W-1:0] w_id_q, w_id_d;
   idx_t            w_idx_q, w_idx_d;
   logic [7:0]      w_len_q, w_len_d;
   logic [7:0]      w_cnt_q, w_cnt_d;
   logic            w_err_q, w_err_d;
   logic            mem_we;

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      mem_we    = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            awready = active_q;
            if (awvalid && active_q) begin
               w_id_d    = awid;
               w_idx_d   = awaddr[MEM_LD+5:6];
               w_len_d   = awlen;
               w_cnt_d   = 8'd0;
               w_err_d   = aw_err;
               w_state_d = WData;
            end
         end
         WData: begin
            wready = 1'b1;
            if (wvalid) begin
               // Burst length comes from awlen alone; wlast is not consulted.
               mem_we  = !w_err_q;
               w_idx_d = w_idx_q + idx_t'(1);
               w_cnt_d = w_cnt_q + 8'd1;
               if (w_cnt_q == w_len_q) begin
                  w_state_d = WResp;
               end
            end
         end
         WResp: begin
            bvalid = 1'b1;
            if (bready) begin
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= WIdle;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
      end
   end

   assign bid   = w_id_q;
   assign bresp = {bvalid & w_err_q, 1'b0};

   // ---------------------------------------------------------------- memory
   logic         rd_en;
   idx_t         rd_idx;
   logic [511:0] mem_q;

   // One RAM per byte lane gives a native byte-enable write and a registered read-first port.
   for (genvar g = 0; g < 64; g++) begin : g_lane
      logic [7:0] lane_mem [Depth];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
         if (mem_we && wstrb[g]) begin
            lane_mem[w_idx_q] <= wdata[8*g +: 8];
         end
      end

      always_ff @(posedge clk) begin
         if (rd_en) begin
            lane_rd_q <= lane_mem[rd_idx];
         end
      end

      assign mem_q[8*g +: 8] = lane_rd_q;
   end

   // ---------------------------------------------------------------- read path
   r_state_e        r_state_q, r_state_d;
   logic [ID_W-1:0] r_id_q, r_id_d;
   idx_t            r_idx_q, r_idx_d;
   logic [7:0]      r_len_q, r_len_d;
   logic [7:0]      r_iss_q, r_iss_d;
   logic            r_done_q, r_done_d;
   logic            r_err_q, r_err_d;
   logic            rd_last;

   logic            pend_q, pend_last_q;
   logic [511:0]    sk_data0_q, sk_data1_q;
   logic [511:0]    push_data;
   logic [1:0]      sk_last_q;
   logic            sk_wptr_q, sk_rptr_q;
   logic [1:0]      sk_cnt_q;
   logic            sk_pop, sk_credit;
   logic [2:0]      sk_fill;

   assign rvalid    = (sk_cnt_q != 2'd0);
   assign rdata     = sk_rptr_q ? sk_data1_q : sk_data0_q;
   assign rlast     = rvalid & sk_last_q[sk_rptr_q];
   assign rid       = r_id_q;
   assign rresp     = {rvalid & r_err_q, 1'b0};
   assign sk_pop    = rvalid & rready;
   // A new fetch may only start if its data is guaranteed a slot when it lands next cycle.
   assign sk_fill   = {1'b0, sk_cnt_q} + {2'b0, pend_q} - {2'b0, sk_pop};
   assign sk_credit = (sk_fill <= 3'd1);
   assign push_data = r_err_q ? '0 : mem_q;

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_iss_d   = r_iss_q;
      r_done_d  = r_done_q;
      r_err_d   = r_err_q;
      arready   = 1'b0;
      rd_en     = 1'b0;
      rd_last   = 1'b0;
      rd_idx    = r_idx_q;
      unique case (r_state_q)
         RIdle: begin
            arready = active_q;
            rd_idx  = araddr[MEM_LD+5:6];
            if (arvalid && active_q) begin
               // First beat is fetched on the handshake edge itself.
               rd_en     = 1'b1;
               rd_last   = (arlen == 8'd0);
               r_id_d    = arid;
               r_len_d   = arlen;
               r_err_d   = ar_err;
               r_idx_d   = rd_idx + idx_t'(1);
               r_iss_d   = 8'd1;
               r_done_d  = rd_last;
               r_state_d = RData;
            end
         end
         RData: begin
            if (!r_done_q && sk_credit) begin
               rd_en    = 1'b1;
               rd_last  = (r_iss_q == r_len_q);
               r_idx_d  = r_idx_q + idx_t'(1);
               r_iss_d  = r_iss_q + 8'd1;
               r_done_d = rd_last;
            end
            if (sk_pop && rlast) begin
               r_state_d = RIdle;
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q   <= RIdle;
         r_id_q      <= '0;
         r_idx_q     <= '0;
         r_len_q     <= '0;
         r_iss_q     <= '0;
         r_done_q    <= 1'b0;
         r_err_q     <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         sk_last_q   <= '0;
         sk_wptr_q   <= 1'b0;
         sk_rptr_q   <= 1'b0;
         sk_cnt_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_iss_q   <= r_iss_d;
         r_done_q  <= r_done_d;
         r_err_q   <= r_err_d;
         pend_q    <= rd_en;
         if (rd_en) begin
            pend_last_q <= rd_last;
         end
         if (pend_q) begin
            sk_last_q[sk_wptr_q] <= pend_last_q;
            sk_wptr_q            <= ~sk_wptr_q;
         end
         if (sk_pop) begin
            sk_rptr_q <= ~sk_rptr_q;
         end
         sk_cnt_q <= sk_cnt_q + {1'b0, pend_q} - {1'b0, sk_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (pend_q && !sk_wptr_q) begin
         sk_data0_q <= push_data;
      end
      if (pend_q && sk_wptr_q) begin
         sk_data1_q <= push_data;
      end
   end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed scenarios for axi_mem_slave with hand-derived expected lines.
// Expected data for every line is pat(salt) of the write that last touched it.
module tb_axi_mem_slave;

   localparam int unsigned MEM_LD = 10;
   localparam int unsigned ID_W   = 16;
   localparam int unsigned ADDR_W = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ID_W-1:0]   awid = '0;
   logic [ADDR_W-1:0] awaddr = '0;
   logic [7:0]        awlen = '0;
   logic [2:0]        awsize = 3'b110;
   logic              awvalid = 1'b0;
   logic              awready;
   logic [511:0]      wdata = '0;
   logic [63:0]       wstrb = '0;
   logic              wlast = 1'b0;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready = 1'b0;
   logic [ID_W-1:0]   arid = '0;
   logic [ADDR_W-1:0] araddr = '0;
   logic [7:0]        arlen = '0;
   logic [2:0]        arsize = 3'b110;
   logic              arvalid = 1'b0;
   logic              arready;
   logic [ID_W-1:0]   rid;
   logic [511:0]      rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready = 1'b0;

   axi_mem_slave #(.MEM_LD(MEM_LD), .ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [511:0] rd_data [256];
   logic         rd_last [256];
   logic [1:0]   rd_resp [256];
   logic [15:0]  rd_id   [256];
   int           rd_beats, rd_lat, rd_unstable;
   logic [15:0]  wr_bid;
   logic [1:0]   wr_bresp;
   time          aw_hs_t, ar_hs_t;

   function automatic logic [511:0] pat(input int unsigned k);
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[32*i +: 32] = k * 32'h0101_0101 + i * 32'h9E37_79B9;
      return v;
   endfunction

   // Full write transaction; beat b carries pat(salt + b), strobes all ones except on sp_beat.
   task automatic axi_write(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int unsigned salt, input int sp_beat, input logic [63:0] sp_strb);
      int t;
      awid = id; awaddr = addr; awlen = len; awsize = 3'b110; awvalid = 1'b1;
      t = 0;
      while (awready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 200) begin n_err++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
      @(posedge clk);
      aw_hs_t = $time;
      @(negedge clk);
      awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata  = pat(salt + b);
         wstrb  = (b == sp_beat) ? sp_strb : '1;
         wlast  = (b == int'(len));
         wvalid = 1'b1;
         t = 0;
         while (wready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
         n_cmp++;
         if (t >= 200) begin n_err++; $display("FAIL w_timeout: wready=%b required 1", wready); end
         @(posedge clk);
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      t = 0;
      while (bvalid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 200) begin n_err++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
      wr_bid = bid; wr_bresp = bresp;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
   endtask

   // Read transaction; rready follows rmask, capture stops at rlast or after abort_at beats.
   task automatic axi_read(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [31:0] rmask, input int abort_at);
      int t, k;
      bit done, prev_stall;
      logic [511:0] prev_data;
      logic prev_last;
      arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
      t = 0;
      while (arready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 200) begin n_err++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
      @(posedge clk);
      ar_hs_t = $time;
      rd_beats = 0; rd_lat = -1; rd_unstable = 0; done = 0; prev_stall = 0; k = 0;
      prev_data = '0; prev_last = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      while (!done && k < 2000) begin
         k++;
         if (rvalid === 1'b1 && rd_lat < 0) rd_lat = k;
         if (prev_stall && (rvalid !== 1'b1 || rdata !== prev_data || rlast !== prev_last))
            rd_unstable++;
         rready = rmask[k % 32];
         if (rvalid === 1'b1 && rready === 1'b1) begin
            if (rd_beats < 256) begin
               rd_data[rd_beats] = rdata; rd_last[rd_beats] = rlast;
               rd_resp[rd_beats] = rresp; rd_id[rd_beats] = rid;
            end
            rd_beats++;
            if (rlast === 1'b1 || rd_beats == abort_at) done = 1;
         end
         prev_stall = (rvalid === 1'b1) && (rready !== 1'b1);
         prev_data  = rdata;
         prev_last  = rlast;
         @(posedge clk);
         @(negedge clk);
      end
      rready = 1'b0;
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL r_timeout: beats=%0d, burst not completed", rd_beats); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: aw/ar/w ready, bvalid, rvalid, rlast = %b required 000000",
                  {awready, arready, wready, bvalid, rvalid, rlast});
      end
      n_cmp++;
      if (bid !== 16'h0) begin n_err++; $display("FAIL reset_bid: got %h required 0000", bid); end
      n_cmp++;
      if (rid !== 16'h0) begin n_err++; $display("FAIL reset_rid: got %h required 0000", rid); end
      n_cmp++;
      if ({bresp, rresp} !== 4'b0) begin
         n_err++; $display("FAIL reset_resp: bresp,rresp = %b required 0000", {bresp, rresp});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
         n_err++;
         $display("FAIL post_reset: aw/ar/w ready, bvalid, rvalid = %b required 11000",
                  {awready, arready, wready, bvalid, rvalid});
      end
   endtask

   task automatic test_single();
      logic [511:0] exp_a;
      exp_a = pat(1);
      axi_write(16'hA5A5, 64'h40, 8'd0, 1, -1, '1);
      n_cmp++;
      if (wr_bresp !== 2'b00) begin n_err++; $display("FAIL single_bresp: got %b required 00", wr_bresp); end
      n_cmp++;
      if (wr_bid !== 16'hA5A5) begin n_err++; $display("FAIL single_bid: got %h required a5a5", wr_bid); end
      axi_read(16'h1234, 64'h40, 8'd0, 3'b110, 32'hFFFF_FFFF, 0);
      n_cmp++;
      if (rd_beats !== 1) begin n_err++; $display("FAIL single_beats: got %0d required 1", rd_beats); end
      n_cmp++;
      if (rd_data[0] !== exp_a) begin
         n_err++; $display("FAIL single_rdata: got %h required %h", rd_data[0], exp_a);
      end
      n_cmp++;
      if (rd_last[0] !== 1'b1) begin n_err++; $display("FAIL single_rlast: got %b required 1", rd_last[0]); end
      n_cmp++;
      if (rd_lat !== 2) begin n_err++; $display("FAIL single_latency: got %0d required 2", rd_lat); end
      n_cmp++;
      if ({rd_id[0], rd_resp[0]} !== {16'h1234, 2'b00}) begin
         n_err++; $display("FAIL single_rid_rresp: got %h/%b required 1234/00", rd_id[0], rd_resp[0]);
      end
   endtask

   task automatic test_burst_strb();
      logic [511:0] exp_line, oldv, newv;
      axi_write(16'h0001, 64'h0, 8'd15, 50, -1, '1);
      axi_write(16'h0002, 64'h0, 8'd7, 100, 3, 64'h0000_0000_0000_FFFF);
      axi_read(16'h0003, 64'h0, 8'd7, 3'b110, 32'hFFFF_FFFF, 0);
      n_cmp++;
      if (rd_beats !== 8) begin n_err++; $display("FAIL strb_beats: got %0d required 8", rd_beats); end
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            oldv = pat(53); newv = pat(103);
            exp_line = {oldv[511:128], newv[127:0]};
         end else begin
            exp_line = pat(100 + i);
         end
         n_cmp++;
         if (rd_data[i] !== exp_line) begin
            n_err++; $display("FAIL strb_line%0d: got %h required %h", i, rd_data[i], exp_line);
         end
      end
   endtask

   task automatic test_rready_toggle();
      logic [511:0] exp_line, oldv, newv;
      int last_err;
      axi_read(16'h00C3, 64'h0, 8'd15, 3'b110, 32'h6C9A_7359, 0);
      n_cmp++;
      if (rd_beats !== 16) begin n_err++; $display("FAIL toggle_beats: got %0d required 16", rd_beats); end
      n_cmp++;
      if (rd_unstable !== 0) begin
         n_err++; $display("FAIL toggle_stable: %0d unstable stalls, required 0", rd_unstable);
      end
      last_err = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 3) begin
            oldv = pat(53); newv = pat(103);
            exp_line = {oldv[511:128], newv[127:0]};
         end else if (i < 8) begin
            exp_line = pat(100 + i);
         end else begin
            exp_line = pat(50 + i);
         end
         n_cmp++;
         if (rd_data[i] !== exp_line) begin
            n_err++; $display("FAIL toggle_beat%0d: got %h required %h", i, rd_data[i], exp_line);
         end
         if (rd_last[i] !== (i == 15)) last_err++;
      end
      n_cmp++;
      if (last_err !== 0) begin
         n_err++; $display("FAIL toggle_rlast: %0d beats with wrong rlast, required 0", last_err);
      end
   endtask

   task automatic test_wrap();
      logic [511:0] exp_line;
      axi_write(16'h0AAA, 64'hFF80, 8'd3, 200, -1, '1);
      axi_read(16'h0BBB, 64'hFF80, 8'd3, 3'b110, 32'hFFFF_FFFF, 0);
      for (int i = 0; i < 4; i++) begin
         exp_line = pat(200 + i);
         n_cmp++;
         if (rd_data[i] !== exp_line) begin
            n_err++; $display("FAIL wrap_beat%0d: got %h required %h", i, rd_data[i], exp_line);
         end
      end
      axi_read(16'h0BBC, 64'h80, 8'd0, 3'b110, 32'hFFFF_FFFF, 0);
      exp_line = pat(102);
      n_cmp++;
      if (rd_data[0] !== exp_line) begin
         n_err++; $display("FAIL wrap_line2_untouched: got %h required %h", rd_data[0], exp_line);
      end
   endtask

   task automatic test_simul();
      logic [511:0] exp_line;
      fork
         axi_write(16'h0007, 64'h140, 8'd0, 300, -1, '1);
         axi_read(16'h0008, 64'h140, 8'd0, 3'b110, 32'hFFFF_FFFF, 0);
      join
      n_cmp++;
      if (aw_hs_t !== ar_hs_t) begin
         n_err++; $display("FAIL simul_same_cycle: aw at %0t, ar at %0t, required equal", aw_hs_t, ar_hs_t);
      end
      exp_line = pat(105);
      n_cmp++;
      if (rd_data[0] !== exp_line) begin
         n_err++; $display("FAIL simul_read_old: got %h required %h", rd_data[0], exp_line);
      end
      n_cmp++;
      if ({wr_bid, wr_bresp} !== {16'h0007, 2'b00}) begin
         n_err++; $display("FAIL simul_b: got %h/%b required 0007/00", wr_bid, wr_bresp);
      end
      axi_read(16'h0009, 64'h140, 8'd0, 3'b110, 32'hFFFF_FFFF, 0);
      exp_line = pat(300);
      n_cmp++;
      if (rd_data[0] !== exp_line) begin
         n_err++; $display("FAIL simul_read_new: got %h required %h", rd_data[0], exp_line);
      end
   endtask

   task automatic test_reset_mid();
      logic [511:0] exp_line;
      axi_read(16'h0010, 64'h0, 8'd15, 3'b110, 32'hFFFF_FFFF, 5);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rvalid, arready} !== 2'b00) begin
         n_err++; $display("FAIL midreset: rvalid,arready = %b required 00", {rvalid, arready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (arready !== 1'b1) begin n_err++; $display("FAIL midreset_arready: got %b required 1", arready); end
      axi_read(16'h0011, 64'h100, 8'd1, 3'b110, 32'hFFFF_FFFF, 0);
      exp_line = pat(104);
      n_cmp++;
      if (rd_data[0] !== exp_line) begin
         n_err++; $display("FAIL midreset_beat0: got %h required %h", rd_data[0], exp_line);
      end
      exp_line = pat(300);
      n_cmp++;
      if (rd_data[1] !== exp_line || rd_last[1] !== 1'b1) begin
         n_err++; $display("FAIL midreset_beat1: got %h last %b required %h last 1",
                           rd_data[1], rd_last[1], exp_line);
      end
   endtask

`ifdef AXI_MEM_SLAVE_ERR_EN
   task automatic test_err();
      logic [511:0] exp_line;
      int bad;
      axi_write(16'h0020, 64'h0000_0100_0000_0180, 8'd0, 400, -1, '1);
      n_cmp++;
      if (wr_bresp !== 2'b10) begin n_err++; $display("FAIL err_bresp: got %b required 10", wr_bresp); end
      axi_read(16'h0021, 64'h180, 8'd0, 3'b110, 32'hFFFF_FFFF, 0);
      exp_line = pat(106);
      n_cmp++;
      if (rd_data[0] !== exp_line) begin
         n_err++; $display("FAIL err_no_write: got %h required %h", rd_data[0], exp_line);
      end
      axi_read(16'h0022, 64'h0000_0100_0000_0000, 8'd2, 3'b110, 32'hFFFF_FFFF, 0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (rd_data[i] !== '0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 2)) bad++;
      end
      n_cmp++;
      if (bad !== 0 || rd_beats !== 3) begin
         n_err++; $display("FAIL err_read: %0d bad beats of %0d, required 0 of 3", bad, rd_beats);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_burst_strb();
      test_rready_toggle();
      test_wrap();
      test_simul();
      test_reset_mid();
`ifdef AXI_MEM_SLAVE_ERR_EN
      test_err();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
